// File: rtl/model_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : model_arbiter_pkg
// Description : Shared definitions for the engine arbiters (matrix, vector,
//               tensor): arbitration state encoding and control constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package model_arbiter_pkg;

  // Arbitration sequence: pick a client, pulse the engine start, wait for the
  // engine to finish, then give the finished client one cycle to drop REQUEST.
  typedef enum logic [1:0] {
    IDLE_STATE    = 2'd0,
    START_STATE   = 2'd1,
    BUSY_STATE    = 2'd2,
    RELEASE_STATE = 2'd3
  } arb_state_e;

  localparam int unsigned ZERO_CONTROL = 0;
  localparam int unsigned ONE_CONTROL  = 1;

endpackage : model_arbiter_pkg
`default_nettype wire

// File: rtl/model_round_robin_picker.sv
`default_nettype none
// ============================================================================
// Module      : model_round_robin_picker
// Description : Combinational round-robin selector. Returns the first asserted
//               request at or after the pointer, wrapping modulo REQUESTERS.
// Ports       : request [REQUESTERS]  - level requests
//               pointer [INDEX_SIZE]  - highest-priority index this round
//               valid                 - at least one request asserted
//               index   [INDEX_SIZE]  - winning client index
// Revision    : 1.0 - initial release
// ============================================================================
module model_round_robin_picker #(
  parameter int REQUESTERS = 4,
  parameter int INDEX_SIZE = 2
) (
  input  logic [REQUESTERS-1:0] request,
  input  logic [INDEX_SIZE-1:0] pointer,
  output logic                  valid,
  output logic [INDEX_SIZE-1:0] index
);

  localparam logic [INDEX_SIZE:0] c_count = (INDEX_SIZE+1)'(REQUESTERS);

  // One extra bit so pointer + offset cannot overflow before the wrap.
  logic [INDEX_SIZE:0] cand;

  // Scan offsets from farthest to nearest; the nearest hit is written last
  // and therefore wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      cand = {1'b0, pointer} + (INDEX_SIZE+1)'(k);
      if (cand >= c_count) begin
        cand = cand - c_count;
      end
      if (request[cand[INDEX_SIZE-1:0]]) begin
        valid = 1'b1;
        index = cand[INDEX_SIZE-1:0];
      end
    end
  end

endmodule : model_round_robin_picker
`default_nettype wire

// File: rtl/model_matrix_multiplication_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : model_matrix_multiplication_arbiter
// Description : Round-robin arbiter sharing one matrix-multiplication engine
//               between REQUESTERS clients. Latches the winner's dimensions,
//               pulses ENGINE_START, steers the winner's input stream to the
//               engine and routes engine enables / READY back to it only.
// Ports       : CLK, RST (async, active-high)
//               REQUEST/GRANT/GRANT_INDEX/READY/ERROR - client handshake
//               SIZE_I_IN/SIZE_J_IN/LENGTH_IN/DATA_IN + input enables - packed
//                 per-client job description and element stream
//               DATA_OUT + output enables - engine result to the granted client
//               ENGINE_* - connection to the single engine instance
// Revision    : 1.0 - initial release
// ============================================================================
module model_matrix_multiplication_arbiter
  import model_arbiter_pkg::*;
#(
  parameter  int DATA_SIZE    = 64,
  parameter  int CONTROL_SIZE = 64,
  parameter  int REQUESTERS   = 4,
  localparam int INDEX_SIZE   = $clog2(REQUESTERS)
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [REQUESTERS-1:0]              REQUEST,
  output logic [REQUESTERS-1:0]              GRANT,
  output logic [INDEX_SIZE-1:0]              GRANT_INDEX,
  output logic [REQUESTERS-1:0]              READY,
  output logic [REQUESTERS-1:0]              ERROR,
  input  logic [REQUESTERS*CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [REQUESTERS*CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [REQUESTERS*CONTROL_SIZE-1:0] LENGTH_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0]    DATA_IN,
  input  logic [REQUESTERS-1:0]              DATA_IN_MATRIX_ENABLE,
  input  logic [REQUESTERS-1:0]              DATA_IN_VECTOR_ENABLE,
  input  logic [REQUESTERS-1:0]              DATA_IN_SCALAR_ENABLE,
  output logic [DATA_SIZE-1:0]               DATA_OUT,
  output logic [REQUESTERS-1:0]              DATA_OUT_MATRIX_ENABLE,
  output logic [REQUESTERS-1:0]              DATA_OUT_VECTOR_ENABLE,
  output logic [REQUESTERS-1:0]              DATA_OUT_SCALAR_ENABLE,
  output logic                               ENGINE_START,
  input  logic                               ENGINE_READY,
  output logic [CONTROL_SIZE-1:0]            ENGINE_SIZE_I,
  output logic [CONTROL_SIZE-1:0]            ENGINE_SIZE_J,
  output logic [CONTROL_SIZE-1:0]            ENGINE_LENGTH,
  output logic [DATA_SIZE-1:0]               ENGINE_DATA_IN,
  output logic                               ENGINE_DATA_IN_MATRIX_ENABLE,
  output logic                               ENGINE_DATA_IN_VECTOR_ENABLE,
  output logic                               ENGINE_DATA_IN_SCALAR_ENABLE,
  input  logic [DATA_SIZE-1:0]               ENGINE_DATA_OUT,
  input  logic                               ENGINE_DATA_OUT_MATRIX_ENABLE,
  input  logic                               ENGINE_DATA_OUT_VECTOR_ENABLE,
  input  logic                               ENGINE_DATA_OUT_SCALAR_ENABLE
);

  localparam logic [INDEX_SIZE-1:0]   c_last_index = INDEX_SIZE'(REQUESTERS - 1);
  localparam logic [CONTROL_SIZE-1:0] c_zero_dim   = CONTROL_SIZE'(ZERO_CONTROL);

  arb_state_e                state_q, state_d;
  logic [INDEX_SIZE-1:0]     pointer_q, pointer_d;
  logic [INDEX_SIZE-1:0]     grant_index_q, grant_index_d;
  logic [REQUESTERS-1:0]     grant_q, grant_d;
  logic [REQUESTERS-1:0]     ready_q, ready_d;
  logic [REQUESTERS-1:0]     error_q, error_d;
  logic [CONTROL_SIZE-1:0]   size_i_q, size_i_d;
  logic [CONTROL_SIZE-1:0]   size_j_q, size_j_d;
  logic [CONTROL_SIZE-1:0]   length_q, length_d;

  logic [CONTROL_SIZE-1:0]   size_i_arr [REQUESTERS];
  logic [CONTROL_SIZE-1:0]   size_j_arr [REQUESTERS];
  logic [CONTROL_SIZE-1:0]   length_arr [REQUESTERS];
  logic [DATA_SIZE-1:0]      data_arr   [REQUESTERS];

  logic                      pick_valid;
  logic [INDEX_SIZE-1:0]     pick_index;
  logic                      pick_zero_dim;
  logic                      busy;

  for (genvar k = 0; k < REQUESTERS; k++) begin : g_unpack
    assign size_i_arr[k] = SIZE_I_IN[k*CONTROL_SIZE +: CONTROL_SIZE];
    assign size_j_arr[k] = SIZE_J_IN[k*CONTROL_SIZE +: CONTROL_SIZE];
    assign length_arr[k] = LENGTH_IN[k*CONTROL_SIZE +: CONTROL_SIZE];
    assign data_arr[k]   = DATA_IN[k*DATA_SIZE +: DATA_SIZE];
  end

  model_round_robin_picker #(
    .REQUESTERS (REQUESTERS),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_picker (
    .request (REQUEST),
    .pointer (pointer_q),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  function automatic logic [INDEX_SIZE-1:0] next_index(input logic [INDEX_SIZE-1:0] idx);
    if (idx == c_last_index) begin
      return '0;
    end
    return idx + INDEX_SIZE'(ONE_CONTROL);
  endfunction

  assign pick_zero_dim = (size_i_arr[pick_index] == c_zero_dim) ||
                         (size_j_arr[pick_index] == c_zero_dim) ||
                         (length_arr[pick_index] == c_zero_dim);

  always_comb begin
    state_d       = state_q;
    pointer_d     = pointer_q;
    grant_index_d = grant_index_q;
    grant_d       = grant_q;
    size_i_d      = size_i_q;
    size_j_d      = size_j_q;
    length_d      = length_q;
    ready_d       = '0;
    error_d       = '0;
    case (state_q)
      IDLE_STATE: begin
        if (pick_valid) begin
          size_i_d = size_i_arr[pick_index];
          size_j_d = size_j_arr[pick_index];
          length_d = length_arr[pick_index];
          if (pick_zero_dim) begin
            // Rejected job: skip the engine entirely and move past this client.
            error_d[pick_index] = 1'b1;
            pointer_d           = next_index(pick_index);
            state_d             = RELEASE_STATE;
          end else begin
            grant_d             = '0;
            grant_d[pick_index] = 1'b1;
            grant_index_d       = pick_index;
            state_d             = START_STATE;
          end
        end
      end
      START_STATE: begin
        state_d = BUSY_STATE;
      end
      BUSY_STATE: begin
        if (ENGINE_READY) begin
          ready_d[grant_index_q] = 1'b1;
          grant_d                = '0;
          pointer_d              = next_index(grant_index_q);
          state_d                = RELEASE_STATE;
        end
      end
      RELEASE_STATE: begin
        state_d = IDLE_STATE;
      end
      default: begin
        state_d = IDLE_STATE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE_STATE;
      pointer_q     <= '0;
      grant_index_q <= '0;
      grant_q       <= '0;
      ready_q       <= '0;
      error_q       <= '0;
      size_i_q      <= '0;
      size_j_q      <= '0;
      length_q      <= '0;
    end else begin
      state_q       <= state_d;
      pointer_q     <= pointer_d;
      grant_index_q <= grant_index_d;
      grant_q       <= grant_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
      size_i_q      <= size_i_d;
      size_j_q      <= size_j_d;
      length_q      <= length_d;
    end
  end

  assign busy = (state_q == BUSY_STATE);

  assign GRANT         = grant_q;
  assign GRANT_INDEX   = grant_index_q;
  assign READY         = ready_q;
  assign ERROR         = error_q;
  assign ENGINE_START  = (state_q == START_STATE);
  assign ENGINE_SIZE_I = size_i_q;
  assign ENGINE_SIZE_J = size_j_q;
  assign ENGINE_LENGTH = length_q;

  // Input steering: purely combinational so the arbiter adds no data latency.
  assign ENGINE_DATA_IN               = data_arr[grant_index_q];
  assign ENGINE_DATA_IN_MATRIX_ENABLE = busy & DATA_IN_MATRIX_ENABLE[grant_index_q];
  assign ENGINE_DATA_IN_VECTOR_ENABLE = busy & DATA_IN_VECTOR_ENABLE[grant_index_q];
  assign ENGINE_DATA_IN_SCALAR_ENABLE = busy & DATA_IN_SCALAR_ENABLE[grant_index_q];

  // Result data is broadcast; only the granted client sees the enables.
  assign DATA_OUT = ENGINE_DATA_OUT;
  for (genvar k = 0; k < REQUESTERS; k++) begin : g_out_enable
    assign DATA_OUT_MATRIX_ENABLE[k] = busy & grant_q[k] & ENGINE_DATA_OUT_MATRIX_ENABLE;
    assign DATA_OUT_VECTOR_ENABLE[k] = busy & grant_q[k] & ENGINE_DATA_OUT_VECTOR_ENABLE;
    assign DATA_OUT_SCALAR_ENABLE[k] = busy & grant_q[k] & ENGINE_DATA_OUT_SCALAR_ENABLE;
  end

endmodule : model_matrix_multiplication_arbiter
`default_nettype wire

// File: doc/model_matrix_multiplication_arbiter.md
# model_matrix_multiplication_arbiter

Round-robin arbiter that shares one matrix-multiplication engine between `REQUESTERS` clients, such as NTM read heads, the write head and the controller. It grants the engine to one requester at a time and latches that requester's dimensions. It pulses the engine START, steers the granted requester's input stream onto the engine, and routes the engine's output enables and READY back to that requester only. It sits between the clients and the single matrix-multiplication instance in the NTM top level.

## Interface
- `DATA_SIZE`, 64, element width.
- `CONTROL_SIZE`, 64, dimension/index width.
- `REQUESTERS`, 4, number of clients (≥2); `INDEX_SIZE` = $clog2(REQUESTERS), local.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `REQUEST` in REQUESTERS: level request per client.
- `GRANT` out REQUESTERS: one-hot grant.
- `GRANT_INDEX` out INDEX_SIZE: index of the current or last grant.
- `READY` out REQUESTERS: one-cycle done pulse to the granted client.
- `ERROR` out REQUESTERS: one-cycle pulse on a zero-dimension request.
- `SIZE_I_IN`, `SIZE_J_IN`, `LENGTH_IN` in REQUESTERS*CONTROL_SIZE each: packed per-client dimensions.
- `DATA_IN` in REQUESTERS*DATA_SIZE: packed per-client element.
- `DATA_IN_MATRIX_ENABLE`, `DATA_IN_VECTOR_ENABLE`, `DATA_IN_SCALAR_ENABLE` in REQUESTERS each.
- `DATA_OUT` out DATA_SIZE: engine result, broadcast to all clients.
- `DATA_OUT_MATRIX_ENABLE`, `DATA_OUT_VECTOR_ENABLE`, `DATA_OUT_SCALAR_ENABLE` out REQUESTERS each: engine enables gated to the granted client.
- Engine side:
  - `ENGINE_START` out 1; `ENGINE_READY` in 1.
  - `ENGINE_SIZE_I`, `ENGINE_SIZE_J`, `ENGINE_LENGTH` out CONTROL_SIZE each.
  - `ENGINE_DATA_IN` out DATA_SIZE; `ENGINE_DATA_OUT` in DATA_SIZE.
  - `ENGINE_DATA_IN_{MATRIX,VECTOR,SCALAR}_ENABLE` out 1 each.
  - `ENGINE_DATA_OUT_{MATRIX,VECTOR,SCALAR}_ENABLE` in 1 each.

## Operation
- States: IDLE_STATE, START_STATE, BUSY_STATE, RELEASE_STATE.
- Reset values: state IDLE; pointer 0; GRANT, GRANT_INDEX, READY, ERROR and ENGINE_START all 0; latched sizes 0.
- IDLE_STATE:
  - Picks the first asserted REQUEST at or after the pointer, wrapping modulo REQUESTERS.
  - On a pick: latches that client's SIZE_I, SIZE_J and LENGTH, sets GRANT and GRANT_INDEX, and moves to START_STATE.
  - If any latched dimension is 0: pulses ERROR[g], sets no GRANT, advances the pointer to g+1, and moves to RELEASE_STATE.
- START_STATE: ENGINE_START=1 for exactly this cycle, then BUSY_STATE.
- BUSY_STATE:
  - ENGINE_DATA_IN and the three ENGINE_DATA_IN_*_ENABLE follow client g combinationally.
  - The engine output enables drive only client g's DATA_OUT_*_ENABLE bits; all other clients see 0.
  - On ENGINE_READY=1: READY[g]=1 next cycle, GRANT cleared, pointer=g+1 (wraps), then RELEASE_STATE.
- RELEASE_STATE: ignores REQUEST for one cycle so the finished client can drop its request, then returns to IDLE_STATE.
- Outside BUSY_STATE, all ENGINE_DATA_IN_*_ENABLE are forced to 0 and non-granted input enables are discarded.
- A REQUEST deasserted while granted is ignored; the grant holds until ENGINE_READY. There is no abort.
- A REQUEST held high through RELEASE_STATE is a new request at the next IDLE arbitration.

## Timing
- REQUEST rising at edge t (IDLE): GRANT at t+1, ENGINE_START high during t+1..t+2, engine sees START at edge t+2.
- ENGINE_READY sampled at edge r: READY[g] and GRANT=0 at r+1; new arbitration at edge r+2; the earliest next GRANT is at r+3.
- Arbitration overhead is 3 cycles per job beyond engine time.
- Data-path steering is combinational; the arbiter adds zero cycles of data latency.
- Simultaneous requests: the lowest index at or after the pointer wins.
- ENGINE_READY outside BUSY_STATE is ignored.
- RST mid-job: all outputs and the pointer return to reset values immediately; the engine shares RST.

## Structure
- Package `model_arbiter_pkg`: state encodings and ZERO/ONE_CONTROL constants, shared with future arbiters for the vector and tensor engines.
- Sub-module `model_round_robin_picker`: combinational; inputs REQUEST and pointer; outputs a valid flag and the winning index.
- The FSM, latches and steering multiplexers live in the top module.

## Test plan
- **Single request:** REQUESTERS=4; REQUEST=0010 with sizes 2,2,2 → GRANT=0010 one cycle later; one ENGINE_START pulse; READY[1] pulses one cycle after ENGINE_READY.
- **Simultaneous requests:** REQUEST=1111 held → grant order 0,1,2,3,0; no client granted twice before the others are served.
- **Zero dimension:** SIZE_J=0 on client 2 → ERROR[2] pulse, ENGINE_START never asserted, pointer becomes 3.
- **Isolation:** while client 0 is granted, toggle client 3's DATA_IN_MATRIX_ENABLE → ENGINE_DATA_IN_MATRIX_ENABLE tracks client 0 only, and DATA_OUT_*_ENABLE[3] stays 0.
- **Reset mid-job:** RST asserted in BUSY_STATE → GRANT=0 and state IDLE asynchronously; the next request after release is served normally.
- **Early release attempt:** client 1 drops REQUEST mid-job → GRANT held until ENGINE_READY; READY[1] still pulses.
